// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: fetch FSM states, default widths and base opcodes.
package rv32i_pkg;

  localparam int          XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fields.sv
// Combinational slicer splitting a 32-bit RV32I word into its base fields.
module instr_fields (
  input  logic [31:0] instr,
  output logic [6:0]  op_code,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  assign op_code = instr[6:0];
  assign rd      = instr[11:7];
  assign func3   = instr[14:12];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign func7   = instr[31:25];

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request word at pc, hold it for decode,
// and squash in-flight or held fetches when a redirect arrives.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      op_code,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            discard_reg, discard_next;
  logic [31:0]     instr_reg, instr_next;
  logic [XLEN-1:0] instr_pc_reg, instr_pc_next;

  // Redirect targets are always word aligned; the low bits are dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= REQ;
      pc_reg       <= RESET_PC;
      discard_reg  <= 1'b0;
      instr_reg    <= NOP_INSTR;
      instr_pc_reg <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      discard_reg  <= discard_next;
      instr_reg    <= instr_next;
      instr_pc_reg <= instr_pc_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    discard_next  = discard_reg;
    instr_next    = instr_reg;
    instr_pc_next = instr_pc_reg;

    if (redirect_valid) begin
      pc_next = {redirect_pc[XLEN-1:2], 2'b00};
    end

    unique case (state_reg)
      REQ: begin
        // A request accepted alongside a redirect still carries the old pc,
        // so its response must be thrown away.
        if (imem_req_ready) begin
          state_next   = WAIT;
          discard_next = redirect_valid;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_next   = REQ;
          discard_next = 1'b0;
          if (!redirect_valid && !discard_reg) begin
            instr_next    = imem_rsp_data;
            instr_pc_next = pc_reg;
            state_next    = HOLD;
          end
        end else if (redirect_valid) begin
          discard_next = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          state_next = REQ;
        end else if (instr_ready) begin
          pc_next    = pc_reg + XLEN'(4);
          state_next = REQ;
        end
      end
      default: begin
        state_next = REQ;
      end
    endcase
  end

  always_comb begin
    imem_req_valid = !rst && (state_reg == REQ);
    instr_valid    = !rst && (state_reg == HOLD);
  end

  assign imem_req_addr = pc_reg;
  assign instr         = instr_reg;
  assign instr_pc      = instr_pc_reg;

  instr_fields u_instr_fields (
    .instr   (instr_reg),
    .op_code (op_code),
    .func3   (func3),
    .func7   (func7),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector table for fetch/redirect corners, then randomized traffic
// checked against an in-order program-counter model with address-keyed memory.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op_code;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .op_code        (op_code),
    .func3          (func3),
    .func7          (func7),
    .rd             (rd),
    .rs1            (rs1),
    .rs2            (rs2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        rst;
    logic        rq;
    logic        rsv;
    logic [31:0] rsd;
    logic        ir;
    logic        rdv;
    logic [31:0] rdp;
    logic        erv;
    logic [31:0] ea;
    logic        eiv;
    logic [31:0] ei;
    logic [31:0] eip;
  } vec_t;

  localparam int NV = 46;
  vec_t vt[NV];

  function automatic vec_t mk(input logic r, input logic rq, input logic rsv,
                              input logic [31:0] rsd, input logic ir, input logic rdv,
                              input logic [31:0] rdp, input logic erv, input logic [31:0] ea,
                              input logic eiv, input logic [31:0] ei, input logic [31:0] eip);
    vec_t v;
    v.rst = r; v.rq = rq; v.rsv = rsv; v.rsd = rsd; v.ir = ir; v.rdv = rdv; v.rdp = rdp;
    v.erv = erv; v.ea = ea; v.eiv = eiv; v.ei = ei; v.eip = eip;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [31:0] exp_pc, pend_addr, prev_instr, prev_ipc;
  logic        pend, drove_rsp, hs, acc, prev_iv, prev_hs, prev_rd;
  int          dly, n_del;

  initial begin
    rst = 1'b1; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    instr_ready = 0; redirect_valid = 0; redirect_pc = 0;

    // Reset: handshakes masked while rst is high, registers at their reset values.
    @(posedge clk); #1;
    chk("reset_req_valid", imem_req_valid, 0);
    chk("reset_instr_valid", instr_valid, 0);
    @(posedge clk); #1;
    chk("reset_req_valid2", imem_req_valid, 0);
    chk("reset_instr_nop", instr, 32'h0000_0013);
    chk("reset_instr_pc", instr_pc, 32'h0);
    $display("reset: req_valid=%0b instr_valid=%0b instr=%h", imem_req_valid, instr_valid, instr);

    //        rst rq rsv rsd           ir rdv rdp           erv ea            eiv ei            eip
    vt[0]  = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0);
    vt[1]  = mk(0, 0, 1, 32'h0000_2083,0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
    vt[2]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,         1, 32'h0000_2083, 32'h0);
    vt[3]  = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h4,         0, 32'h0,         32'h0);
    vt[4]  = mk(1, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
    vt[5]  = mk(0, 1, 1, 32'hDEAD_BEEF,0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0);
    vt[6]  = mk(0, 0, 1, 32'h0000_0033,0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
    vt[7]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0033, 32'h0);
    vt[8]  = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h4,         0, 32'h0,         32'h0);
    vt[9]  = mk(0, 0, 1, 32'h0040_A023,0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
    vt[10] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,         1, 32'h0040_A023, 32'h4);
    vt[11] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h8,         0, 32'h0,         32'h0);
    vt[12] = mk(0, 0, 1, 32'h4020_80B3,0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
    vt[13] = mk(0, 1, 1, 32'h1111_1111,0, 0, 32'h0,         0, 32'h0,         1, 32'h4020_80B3, 32'h8);
    for (int k = 14; k <= 17; k++)
      vt[k] = mk(0, 1, 0, 32'h0,       0, 0, 32'h0,         0, 32'h0,         1, 32'h4020_80B3, 32'h8);
    vt[18] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,         1, 32'h4020_80B3, 32'h8);
    for (int k = 19; k <= 22; k++)
      vt[k] = mk(0, 0, 0, 32'h0,       0, 0, 32'h0,         1, 32'hC,         0, 32'h0,         32'h0);
    vt[23] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'hC,         0, 32'h0,         32'h0);
    vt[24] = mk(0, 0, 0, 32'h0,        0, 1, 32'h100,       0, 32'h0,         0, 32'h0,         32'h0);
    vt[25] = mk(0, 0, 1, 32'h1234_5678,0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
    vt[26] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h100,       0, 32'h0,         32'h0);
    vt[27] = mk(0, 0, 1, 32'h0010_0093,0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
    vt[28] = mk(0, 0, 0, 32'h0,        1, 1, 32'h203,       0, 32'h0,         1, 32'h0010_0093, 32'h100);
    vt[29] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h200,       0, 32'h0,         32'h0);
    vt[30] = mk(0, 0, 1, 32'h0000_006F,0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
    vt[31] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,         1, 32'h0000_006F, 32'h200);
    vt[32] = mk(0, 1, 0, 32'h0,        0, 1, 32'h300,       1, 32'h204,       0, 32'h0,         32'h0);
    vt[33] = mk(0, 0, 1, 32'h0000_AAAA,0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
    vt[34] = mk(0, 0, 0, 32'h0,        0, 1, 32'h404,       1, 32'h300,       0, 32'h0,         32'h0);
    vt[35] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h404,       0, 32'h0,         32'h0);
    vt[36] = mk(0, 0, 1, 32'h0000_BBBB,0, 1, 32'h500,       0, 32'h0,         0, 32'h0,         32'h0);
    vt[37] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h500,       0, 32'h0,         32'h0);
    vt[38] = mk(0, 0, 1, 32'h0050_0513,0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
    vt[39] = mk(0, 0, 0, 32'h0,        0, 1, 32'h600,       0, 32'h0,         1, 32'h0050_0513, 32'h500);
    vt[40] = mk(0, 0, 1, 32'h2222_2222,0, 0, 32'h0,         1, 32'h600,       0, 32'h0,         32'h0);
    vt[41] = mk(0, 0, 0, 32'h0,        0, 1, 32'hFFFF_FFFE, 1, 32'h600,       0, 32'h0,         32'h0);
    vt[42] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0);
    vt[43] = mk(0, 0, 1, 32'h0000_0033,0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
    vt[44] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0033, 32'hFFFF_FFFC);
    vt[45] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0);

    rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      rst = vt[i].rst; imem_req_ready = vt[i].rq; imem_rsp_valid = vt[i].rsv;
      imem_rsp_data = vt[i].rsd; instr_ready = vt[i].ir;
      redirect_valid = vt[i].rdv; redirect_pc = vt[i].rdp;
      #1;
      chk($sformatf("v%0d req_valid", i), imem_req_valid, vt[i].erv);
      chk($sformatf("v%0d instr_valid", i), instr_valid, vt[i].eiv);
      if (vt[i].erv) chk($sformatf("v%0d req_addr", i), imem_req_addr, vt[i].ea);
      if (vt[i].eiv) begin
        chk($sformatf("v%0d instr", i), instr, vt[i].ei);
        chk($sformatf("v%0d instr_pc", i), instr_pc, vt[i].eip);
        chk($sformatf("v%0d fields", i), {func7, rs2, rs1, func3, rd, op_code}, vt[i].ei);
      end
      if (i == 2) begin
        chk("lw op_code", op_code, 32'b0000011);
        chk("lw rd", rd, 32'd1);
        chk("lw func3", func3, 32'b010);
      end
      if (i == 13) chk("sub func7", func7, 32'b0100000);
      $display("vec %0d: req_valid=%0b addr=%h instr_valid=%0b instr=%h instr_pc=%h",
               i, imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc);
      @(posedge clk); #1;
    end

    // Randomized traffic: delivered instructions must follow program order from
    // the reset pc, advanced by +4 on consumption and replaced on redirect.
    rst = 1'b1; imem_req_ready = 0; imem_rsp_valid = 0; instr_ready = 0; redirect_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pc = 32'h0; pend = 0; dly = 0; n_del = 0; pend_addr = 0;
    prev_iv = 0; prev_hs = 0; prev_rd = 0; prev_instr = 0; prev_ipc = 0;
    for (int c = 0; c < 3000; c++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : ($urandom & 32'h0000_0FFF);
      drove_rsp = 1'b0;
      if (pend && dly == 0) begin
        imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(pend_addr); drove_rsp = 1'b1;
      end else if (!pend && $urandom_range(0, 7) == 0) begin
        imem_rsp_valid = 1'b1; imem_rsp_data = $urandom;
      end else begin
        imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
      end
      #1;
      if (prev_iv && !prev_hs && !prev_rd) begin
        chk("rnd hold_kept", instr_valid, 1);
        chk("rnd hold_stable", instr, prev_instr);
        chk("rnd hold_pc_stable", instr_pc, prev_ipc);
      end
      if (instr_valid) chk("rnd no_req_in_hold", imem_req_valid, 0);
      if (imem_req_valid) chk("rnd addr_aligned", imem_req_addr & 32'h3, 0);
      hs  = instr_valid && instr_ready;
      acc = imem_req_valid && imem_req_ready;
      if (redirect_valid) begin
        exp_pc = redirect_pc & ~32'h3;
      end else if (hs) begin
        chk("rnd instr_pc", instr_pc, exp_pc);
        chk("rnd instr", instr, mem_word(exp_pc));
        chk("rnd fields", {func7, rs2, rs1, func3, rd, op_code}, mem_word(exp_pc));
        $display("rnd deliver %0d: pc=%h instr=%h", n_del, instr_pc, instr);
        n_del++;
        exp_pc = exp_pc + 32'h4;
      end
      prev_iv = instr_valid; prev_hs = hs; prev_rd = redirect_valid;
      prev_instr = instr; prev_ipc = instr_pc;
      if (acc) pend_addr = imem_req_addr;
      @(posedge clk); #1;
      if (drove_rsp) pend = 1'b0;
      else if (pend) dly--;
      if (acc) begin
        pend = 1'b1;
        dly  = $urandom_range(0, 2);
      end
    end
    chk("rnd min_deliveries", (n_del >= 50) ? 32'd1 : 32'd0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
